tx_rd_addr_publisher: RTL and testbench
=======================================

Name: tx_rd_addr_publisher

Overview:
Multi-channel source-side publisher for committed TX read addresses. It watches NCH per-channel address buses and detects changes against the last published value per channel. A round-robin arbiter picks one changed channel, whose value is published as a stable address plus channel-id bundle qualified by a strobe. Each bundle is then held stable for a guaranteed window, so any downstream capture logic (including a 2-flop synchroniser) samples it safely; ACK_MODE adds an optional acknowledge handshake.

Parameters:
NCH, 4, number of channels (1..16)
AW, 16, address width per channel
CW, 2, channel-id width; must satisfy 2**CW >= NCH
PULSE, 2, strobe high cycles when ACK_MODE=0 (>=1)
HOLD, 6, cycles bundle stays stable after strobe deasserts (>=0)
ACK_MODE, 0, 0 = fixed-width strobe; 1 = strobe held until ack

Ports:
clk  in  1  block clock
reset  in  1  synchronous active-high reset
rd_addr_in  in  NCH*AW  channel i at bits [i*AW +: AW]
chan_en  in  NCH  per-channel enable; a disabled channel is never granted
ack  in  1  downstream acknowledge; ignored when ACK_MODE=0
addr_out  out  AW  published address
chan_out  out  CW  channel id of addr_out
strobe  out  1  bundle-valid qualifier
busy  out  1  high in any state other than IDLE
pending  out  NCH  pending[i] = chan_en[i] & (rd_addr_in[i] != last[i]), combinational

Behaviour:
- Reset, sampled on the clk edge with reset=1: addr_out=0, chan_out=0, strobe=0, busy=0, every last[i]=0, rr_ptr=NCH-1, state=IDLE.
- Reset has priority and aborts any transaction immediately. After reset, every enabled channel with a nonzero input is pending.
- State machine states: IDLE, STROBE, HOLD.
- IDLE:
  - When pending!=0, select grant g = first set pending bit, searching from (rr_ptr+1) mod NCH upward with wrap.
  - On that edge: addr_out<=rd_addr_in[g], chan_out<=g, last[g]<=rd_addr_in[g], rr_ptr<=g, strobe<=1, cnt<=0, go to STROBE.
  - When pending==0, outputs keep their last values and strobe stays 0.
- STROBE with ACK_MODE=0:
  - strobe stays high for exactly PULSE cycles.
  - Then strobe<=0, cnt<=0, go to HOLD; if HOLD=0, go to IDLE directly.
- STROBE with ACK_MODE=1:
  - strobe stays high until ack is sampled high, which can be in the first STROBE cycle.
  - Then strobe<=0 and continue to HOLD, or to IDLE if HOLD=0.
  - There is no timeout; the block waits indefinitely for ack.
- HOLD: strobe=0 for HOLD cycles, then go to IDLE.
- Stability guarantee:
  - addr_out and chan_out change only on the IDLE grant edge.
  - They stay constant from that edge through the end of HOLD.
  - addr_out stays 0 and chan_out stays 0 until the first grant after reset.
- Latency and throughput (ACK_MODE=0):
  - An input change visible before edge E is granted at E, so strobe is high during cycles E+1..E+PULSE.
  - Minimum spacing between grant edges is 1+PULSE+HOLD cycles (default 9).
- Coalescing:
  - Changes to rd_addr_in during a transaction are not queued.
  - After IDLE is re-entered, the current value is compared against last; intermediate values may be skipped.
  - A channel that changes and returns to its last value is not published.
- Same-channel re-change: if the granted channel changes again mid-transaction, it is pending again at IDLE. It is re-granted only if no other channel is pending in round-robin order.
- Simultaneous pending channels: exactly one grant per transaction. Over any window, each continuously pending channel is granted within NCH transactions.
- chan_en deasserted mid-transaction: the transaction completes normally and last[] is unaffected. The channel is then excluded from arbitration.
- NCH=1: rr_ptr is trivial and CW may be 1.
- Address compare is a full AW-bit inequality with no wrap arithmetic; wrap-around of the address value (e.g. FFFF->0000) is just a change.

Test Plan:
- Reset then idle: NCH=4 defaults, all inputs 0 -> strobe=0, busy=0, addr_out=0, pending=0 for 50 cycles.
- Single update: ch2 changes 0->0x0123 before edge E -> strobe high for cycles E+1..E+2; addr_out=0x0123 and chan_out=2 stable through E+8; busy low at E+9; pending[2]=0 after E.
- Round-robin fairness: all four channels change together -> grants in order 0,1,2,3, spaced 9 cycles apart. Then ch3 and ch0 change together -> grants 0 then 3.
- Coalescing: ch1 writes 0x10, 0x11 and 0x12 during an active ch0 transaction -> a single ch1 publish with addr_out=0x12. A ch1 change 0x12->0x13->0x12 within one transaction -> no publish.
- ACK_MODE=1, HOLD=2: grant ch0; ack held low for 20 cycles then pulsed high -> strobe stays high until the cycle after ack, then 2 HOLD cycles, then IDLE; addr_out stable throughout.
- Mid-transaction reset, enable, and wrap: reset during STROBE -> next cycle all outputs 0 and last[]=0. With chan_en=4'b1011 and all channels changed -> ch2 never granted. An address wrap 0xFFFF->0x0000 on ch1 -> published.

Source files
------------

// File: rtl/tx_rd_addr_publisher.sv
// Publishes changed per-channel TX read addresses one at a time, round-robin,
// as a strobe-qualified bundle that is held stable for a guaranteed window.
module tx_rd_addr_publisher #(
    parameter int NCH      = 4,
    parameter int AW       = 16,
    parameter int CW       = 2,
    parameter int PULSE    = 2,
    parameter int HOLD     = 6,
    parameter int ACK_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH*AW-1:0] rd_addr_in,
    input  logic [NCH-1:0]    chan_en,
    input  logic              ack,
    output logic [AW-1:0]     addr_out,
    output logic [CW-1:0]     chan_out,
    output logic              strobe,
    output logic              busy,
    output logic [NCH-1:0]    pending
);

    localparam int CNT_MAX = (PULSE > HOLD) ? PULSE : HOLD;
    localparam int CNTW    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNTW-1:0] PULSE_LAST = CNTW'(PULSE - 1);
    localparam logic [CNTW-1:0] HOLD_LAST  = CNTW'((HOLD > 0) ? HOLD - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_HOLD
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [CNTW-1:0]   r_cnt;
    logic [CNTW-1:0]   w_nextCnt;
    logic              r_strobe;
    logic              w_nextStrobe;
    logic              w_grantFire;
    logic              w_exitStrobe;
    logic [AW-1:0]     r_addr;
    logic [CW-1:0]     r_chan;
    logic [CW-1:0]     r_rrPtr;
    logic [AW-1:0]     r_last [NCH];
    logic [AW-1:0]     w_chanAddr [NCH];
    logic [NCH-1:0]    w_pending;
    logic [CW-1:0]     w_grant;
    logic              w_found;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_chanAddr[i] = rd_addr_in[i*AW +: AW];
            w_pending[i]  = chan_en[i] & (w_chanAddr[i] != r_last[i]);
        end
    end

    // Round-robin search starting just after the most recently granted channel.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 1; k <= NCH; k++) begin
            if (!w_found && w_pending[(int'(r_rrPtr) + k) % NCH]) begin
                w_found = 1'b1;
                w_grant = CW'((int'(r_rrPtr) + k) % NCH);
            end
        end
    end

    assign w_exitStrobe = (ACK_MODE != 0) ? ack : (r_cnt == PULSE_LAST);

    always_comb begin
        w_nextState  = r_state;
        w_nextCnt    = r_cnt;
        w_nextStrobe = r_strobe;
        w_grantFire  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grantFire  = 1'b1;
                    w_nextStrobe = 1'b1;
                    w_nextCnt    = '0;
                    w_nextState  = S_STROBE;
                end
            end
            S_STROBE: begin
                if (w_exitStrobe) begin
                    w_nextStrobe = 1'b0;
                    w_nextCnt    = '0;
                    w_nextState  = (HOLD == 0) ? S_IDLE : S_HOLD;
                end else if (ACK_MODE == 0) begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_nextState = S_IDLE;
                end else begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_nextState  = S_IDLE;
                w_nextStrobe = 1'b0;
            end
        endcase
    end

    // The bundle registers only move on the grant edge, which keeps them stable through HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_strobe <= 1'b0;
            r_addr   <= '0;
            r_chan   <= '0;
            r_rrPtr  <= CW'(NCH - 1);
            for (int i = 0; i < NCH; i++) begin
                r_last[i] <= '0;
            end
        end else begin
            r_state  <= w_nextState;
            r_cnt    <= w_nextCnt;
            r_strobe <= w_nextStrobe;
            if (w_grantFire) begin
                r_addr          <= w_chanAddr[w_grant];
                r_chan          <= w_grant;
                r_last[w_grant] <= w_chanAddr[w_grant];
                r_rrPtr         <= w_grant;
            end
        end
    end

    assign addr_out = r_addr;
    assign chan_out = r_chan;
    assign strobe   = r_strobe;
    assign busy     = (r_state != S_IDLE);
    assign pending  = w_pending;

endmodule

// File: tb/tb_tx_rd_addr_publisher.sv
// Scoreboard bench for tx_rd_addr_publisher: a default-configured instance plus
// an ACK_MODE=1, HOLD=2 instance for the acknowledge handshake.
module tb_tx_rd_addr_publisher;

    typedef struct packed {
        logic [1:0]  chan;
        logic [15:0] addr;
    } pub_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] rdA;
    logic [3:0]  enA;
    logic        ackA;
    logic [15:0] addrA;
    logic [1:0]  chanA;
    logic        strobeA;
    logic        busyA;
    logic [3:0]  pendA;
    logic [63:0] rdB;
    logic [3:0]  enB;
    logic        ackB;
    logic [15:0] addrB;
    logic [1:0]  chanB;
    logic        strobeB;
    logic        busyB;
    logic [3:0]  pendB;

    int   assertCount = 0;
    int   failCount   = 0;
    int   cycle       = 0;
    pub_t sbQ [$];
    int   riseQ [$];
    pub_t curExp;
    logic curValid    = 1'b0;
    logic prevStrobeA = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    tx_rd_addr_publisher dutA (
        .clk(clk), .reset(reset), .rd_addr_in(rdA), .chan_en(enA), .ack(ackA),
        .addr_out(addrA), .chan_out(chanA), .strobe(strobeA), .busy(busyA), .pending(pendA)
    );

    tx_rd_addr_publisher #(.ACK_MODE(1), .HOLD(2)) dutB (
        .clk(clk), .reset(reset), .rd_addr_in(rdB), .chan_en(enB), .ack(ackB),
        .addr_out(addrB), .chan_out(chanB), .strobe(strobeB), .busy(busyB), .pending(pendB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int ch, input logic [15:0] value, input bit expectPub);
        pub_t p;
        rdA[ch*16 +: 16] = value;
        if (expectPub) begin
            p.chan = 2'(ch);
            p.addr = value;
            sbQ.push_back(p);
        end
    endtask

    task automatic waitIdle(input int maxCycles);
        int n = 0;
        step();
        while ((busyA || pendA != 4'b0) && n < maxCycles) begin
            step();
            n++;
        end
        checkOutput("idleTimeout", 32'(busyA || pendA != 4'b0), 32'd0);
    endtask

    // Every strobe rise consumes one expected publish; the bundle must then hold while busy.
    always @(negedge clk) begin
        if (strobeA && !prevStrobeA) begin
            riseQ.push_back(cycle);
            if (sbQ.size() == 0) begin
                checkOutput("sbUnderflow", 32'd1, 32'd0);
                curValid = 1'b0;
            end else begin
                curExp   = sbQ.pop_front();
                curValid = 1'b1;
                checkOutput("pubChan", 32'(chanA), 32'(curExp.chan));
                checkOutput("pubAddr", 32'(addrA), 32'(curExp.addr));
            end
        end else if (busyA && curValid) begin
            checkOutput("holdAddr", 32'(addrA), 32'(curExp.addr));
            checkOutput("holdChan", 32'(chanA), 32'(curExp.chan));
        end
        prevStrobeA = strobeA;
    end

    initial begin
        reset = 1'b1;
        rdA   = '0;
        enA   = 4'hF;
        ackA  = 1'b0;
        rdB   = '0;
        enB   = 4'hF;
        ackB  = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        for (int i = 0; i < 50; i++) begin
            step();
            checkOutput("idleStrobe", 32'(strobeA), 32'd0);
            checkOutput("idleBusy", 32'(busyA), 32'd0);
            checkOutput("idleAddr", 32'(addrA), 32'd0);
            checkOutput("idlePend", 32'(pendA), 32'd0);
        end

        $display("[TB] single update on channel 2");
        applyStimulus(2, 16'h0123, 1'b1);
        step();
        checkOutput("singleStrobeE", 32'(strobeA), 32'd1);
        checkOutput("singleChanE", 32'(chanA), 32'd2);
        checkOutput("singleAddrE", 32'(addrA), 32'h0123);
        checkOutput("singlePend2", 32'(pendA[2]), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            step();
            checkOutput("singleStrobe", 32'(strobeA), 32'(k < 2));
            checkOutput("singleBusy", 32'(busyA), 32'(k < 8));
            checkOutput("singleAddr", 32'(addrA), 32'h0123);
        end

        $display("[TB] round-robin after reset");
        reset = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(i, 16'hA000 + 16'(i), 1'b1);
        step();
        step();
        riseQ.delete();
        reset = 1'b0;
        waitIdle(100);
        checkOutput("rrGrants", 32'(riseQ.size()), 32'd4);
        for (int i = 1; i < 4 && i < riseQ.size(); i++) begin
            checkOutput("rrSpacing", 32'(riseQ[i] - riseQ[i-1]), 32'd9);
        end
        applyStimulus(0, 16'hB000, 1'b1);
        applyStimulus(3, 16'hB003, 1'b1);
        waitIdle(50);

        $display("[TB] coalescing");
        applyStimulus(0, 16'hC000, 1'b1);
        step();
        applyStimulus(1, 16'h0010, 1'b0);
        step();
        applyStimulus(1, 16'h0011, 1'b0);
        step();
        applyStimulus(1, 16'h0012, 1'b1);
        waitIdle(60);
        applyStimulus(3, 16'hC003, 1'b1);
        step();
        applyStimulus(1, 16'h0013, 1'b0);
        step();
        applyStimulus(1, 16'h0012, 1'b0);
        waitIdle(60);
        checkOutput("coalescePend", 32'(pendA), 32'd0);

        $display("[TB] acknowledge mode");
        rdB[15:0] = 16'h5A5A;
        step();
        checkOutput("ackStrobeE", 32'(strobeB), 32'd1);
        checkOutput("ackChanE", 32'(chanB), 32'd0);
        checkOutput("ackAddrE", 32'(addrB), 32'h5A5A);
        for (int i = 0; i < 20; i++) begin
            step();
            checkOutput("ackWaitStrobe", 32'(strobeB), 32'd1);
            checkOutput("ackWaitAddr", 32'(addrB), 32'h5A5A);
        end
        ackB = 1'b1;
        step();
        ackB = 1'b0;
        checkOutput("ackDropStrobe", 32'(strobeB), 32'd0);
        checkOutput("ackHold1Busy", 32'(busyB), 32'd1);
        step();
        checkOutput("ackHold2Busy", 32'(busyB), 32'd1);
        checkOutput("ackHold2Addr", 32'(addrB), 32'h5A5A);
        step();
        checkOutput("ackIdleBusy", 32'(busyB), 32'd0);
        checkOutput("ackIdleStrobe", 32'(strobeB), 32'd0);
        checkOutput("ackIdleAddr", 32'(addrB), 32'h5A5A);

        $display("[TB] mid-transaction reset, enables and wrap");
        applyStimulus(1, 16'h0BAD, 1'b1);
        step();
        checkOutput("abortStrobeE", 32'(strobeA), 32'd1);
        reset = 1'b1;
        enA   = 4'b1011;
        applyStimulus(0, 16'h1000, 1'b1);
        applyStimulus(1, 16'h1111, 1'b1);
        applyStimulus(2, 16'h2222, 1'b0);
        applyStimulus(3, 16'h3333, 1'b1);
        step();
        checkOutput("abortAddr", 32'(addrA), 32'd0);
        checkOutput("abortChan", 32'(chanA), 32'd0);
        checkOutput("abortStrobe", 32'(strobeA), 32'd0);
        checkOutput("abortBusy", 32'(busyA), 32'd0);
        checkOutput("abortPend", 32'(pendA), 32'b1011);
        reset = 1'b0;
        waitIdle(100);
        applyStimulus(1, 16'hFFFF, 1'b1);
        waitIdle(30);
        applyStimulus(1, 16'h0000, 1'b1);
        waitIdle(30);
        checkOutput("disabledPend2", 32'(pendA[2]), 32'd0);

        step();
        step();
        checkOutput("sbEmpty", 32'(sbQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
